// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_pkg
// Purpose : Shared defaults and sizing helpers for the fetch stage (address
//           and data widths, reset vector, FIFO pointer/count widths).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package instruction_fetch_pkg;

  localparam int c_default_addr_width = 8;
  localparam int c_default_data_width = 8;
  localparam int c_default_buf_depth  = 2;
  localparam logic [7:0] c_default_reset_vector = 8'h00;

  // Count must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_if
// Purpose : Bundles the ROM address/data bus, the decode valid/ready
//           handshake and the redirect request of the fetch stage.
// Ports   : master = fetch stage (drives ROM_ADDR, INSTR*)
//           slave  = environment (ROM + decode + branch/interrupt logic)
// Rev     : 1.0  initial release
// ============================================================================
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ROM_ADDR;
  logic [DATA_WIDTH-1:0] ROM_DATA;
  logic [DATA_WIDTH-1:0] INSTR;
  logic [ADDR_WIDTH-1:0] INSTR_PC;
  logic                  INSTR_VALID;
  logic                  INSTR_READY;
  logic                  REDIRECT;
  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR;

  modport master (
    output ROM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    input  ROM_DATA, INSTR_READY, REDIRECT, REDIRECT_ADDR
  );

  modport slave (
    input  ROM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    output ROM_DATA, INSTR_READY, REDIRECT, REDIRECT_ADDR
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_fifo
// Purpose : Synchronous prefetch FIFO with flush and occupancy count.
//           Flush has priority over push/pop in the same cycle.
// Ports   : CLK, RESET      clock, synchronous active-high reset
//           i_push/i_wr_data write side
//           i_pop           read side (ignored while empty)
//           i_flush         discard all entries
//           o_rd_data       head entry (raw storage, unqualified)
//           o_empty/o_count occupancy
// Rev     : 1.0  initial release
// ============================================================================
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_wr_data,
  input  logic                          i_pop,
  input  logic                          i_flush,
  output logic [WIDTH-1:0]              o_rd_data,
  output logic                          o_empty,
  output logic [count_width(DEPTH)-1:0] o_count
);

  localparam int c_pw = ptr_width(DEPTH);
  localparam int c_cw = count_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_wr_ptr;
  logic [c_pw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] p);
    return (p == c_pw'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cw'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge CLK) begin
    if (RESET || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; power-on contents are never observed because
  // the head is qualified by o_empty downstream.
  always_ff @(posedge CLK) begin
    if (w_do_push && !i_flush && !RESET) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Purpose : Program counter and fetch stage in front of a 1-cycle registered
//           instruction ROM. Tracks the in-flight read, captures returned
//           bytes into a prefetch buffer and presents them to decode over a
//           valid/ready handshake. REDIRECT flushes buffered and in-flight
//           bytes and restarts fetching at REDIRECT_ADDR.
// Ports   : CLK    system clock
//           RESET  synchronous active-high reset
//           bus    instruction_fetch_if.master (ROM bus, decode handshake,
//                  redirect request)
// Rev     : 1.0  initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = c_default_addr_width,
  parameter int                    DATA_WIDTH   = c_default_data_width,
  parameter int                    BUF_DEPTH    = c_default_buf_depth,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = c_default_reset_vector
) (
  input  logic                 CLK,
  input  logic                 RESET,
  instruction_fetch_if.master  bus
);

  localparam int c_cw = count_width(BUF_DEPTH);
  localparam int c_ew = DATA_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic [c_cw-1:0]       w_count;
  logic                  w_empty;
  logic [c_ew-1:0]       w_head;
  logic                  w_pop;
  logic                  w_issue;
  logic [c_cw:0]         w_occupancy;
  logic [c_cw:0]         w_limit;

  assign w_pop = ~w_empty & bus.INSTR_READY;

  // Credit check: count + inflight - pop < BUF_DEPTH, rearranged so the
  // arithmetic never goes negative. Counting the in-flight byte is what
  // guarantees the buffer cannot overflow.
  assign w_occupancy = {1'b0, w_count} + (c_cw + 1)'(r_inflight);
  assign w_limit     = (c_cw + 1)'(BUF_DEPTH) + (c_cw + 1)'(w_pop);
  assign w_issue     = ~bus.REDIRECT & (w_occupancy < w_limit);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.REDIRECT) begin
      // The ROM is still reading the old address; dropping r_inflight
      // discards that byte when it returns.
      r_fetch_pc <= bus.REDIRECT_ADDR;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  instruction_fetch_fifo #(
    .WIDTH (c_ew),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_push    (r_inflight),
    .i_wr_data ({bus.ROM_DATA, r_inflight_pc}),
    .i_pop     (w_pop),
    .i_flush   (bus.REDIRECT),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign bus.ROM_ADDR    = r_fetch_pc;
  assign bus.INSTR_VALID = ~w_empty;
  assign bus.INSTR       = w_empty ? '0 : w_head[c_ew-1 -: DATA_WIDTH];
  assign bus.INSTR_PC    = w_empty ? '0 : w_head[ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch
// Purpose : Self-checking bench for instruction_fetch. A ROM model returns
//           ROM[i] = i ^ 8'hA5 one cycle after the address; a queue-based
//           model predicts the buffered PCs, the fetch PC and the in-flight
//           slot from the fetch rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int         c_aw    = 8;
  localparam int         c_dw    = 8;
  localparam int         c_depth = 2;
  localparam logic [7:0] c_rv    = 8'h00;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  instruction_fetch_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) bus ();

  instruction_fetch #(
    .ADDR_WIDTH   (c_aw),
    .DATA_WIDTH   (c_dw),
    .BUF_DEPTH    (c_depth),
    .RESET_VECTOR (c_rv)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Registered ROM
  always @(posedge CLK) bus.ROM_DATA <= bus.ROM_ADDR ^ 8'hA5;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: PCs sitting in the buffer (in order), the PC whose
  // ROM read is in flight, and the next PC to fetch.
  logic [7:0] m_q[$];
  bit         m_infl;
  logic [7:0] m_ipc;
  logic [7:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit redir, input logic [7:0] raddr, input bit rdy);
    bit         pop;
    bit         hold;
    int         occ;
    logic [7:0] h_instr;
    logic [7:0] h_pc;

    RESET             = rst;
    bus.REDIRECT      = redir;
    bus.REDIRECT_ADDR = raddr;
    bus.INSTR_READY   = rdy;

    pop     = (m_q.size() > 0) && rdy;
    hold    = (bus.INSTR_VALID === 1'b1) && !rdy && !rst && !redir;
    h_instr = bus.INSTR;
    h_pc    = bus.INSTR_PC;

    if (rst) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = c_rv;
    end else if (redir) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = raddr;
    end else begin
      occ = m_q.size() + int'(m_infl) - int'(pop);
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_ipc);
      if (occ < c_depth) begin
        m_infl = 1'b1;
        m_ipc  = m_pc;
        m_pc   = m_pc + 8'd1;
      end else begin
        m_infl = 1'b0;
      end
    end

    @(posedge CLK);
    #1;

    chk("rom_addr", bus.ROM_ADDR, m_pc);
    chk("valid", bus.INSTR_VALID, m_q.size() > 0);
    chk("instr", bus.INSTR, (m_q.size() > 0) ? (m_q[0] ^ 8'hA5) : 8'h00);
    chk("instr_pc", bus.INSTR_PC, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("count", u_dut.w_count, m_q.size());
    chk("count_bound", u_dut.w_count <= c_depth, 1);
    if (hold) begin
      chk("hold_instr", bus.INSTR, h_instr);
      chk("hold_pc", bus.INSTR_PC, h_pc);
    end
  endtask

  initial begin
    bit         r_rdy;
    bit         r_redir;
    bit         r_rst;
    logic [7:0] r_addr;

    RESET             = 1'b1;
    bus.REDIRECT      = 1'b0;
    bus.REDIRECT_ADDR = 8'h00;
    bus.INSTR_READY   = 1'b0;
    @(posedge CLK);
    #1;

    // Reset, then streaming with READY high
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    repeat (8) step(0, 0, 8'h00, 1);

    // Restart, then READY low from c2 for 5 cycles, then resume
    step(1, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    repeat (5) step(0, 0, 8'h00, 0);
    repeat (6) step(0, 0, 8'h00, 1);

    // Redirect to 40 with a full buffer
    repeat (3) step(0, 0, 8'h00, 0);
    step(0, 1, 8'h40, 0);
    repeat (5) step(0, 0, 8'h00, 1);

    // PC wrap FE -> FF -> 00 -> 01
    step(0, 1, 8'hFE, 1);
    repeat (7) step(0, 0, 8'h00, 1);

    // Reset mid-stream with a full buffer
    repeat (4) step(0, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    repeat (5) step(0, 0, 8'h00, 1);

    // Redirect together with a pop, then redirect held with changing targets
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h10, 1);
    repeat (3) step(0, 1, 8'($urandom), 1);
    repeat (6) step(0, 0, 8'h00, 1);

    // Randomized traffic
    repeat (400) begin
      r_rdy   = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 19) == 0);
      r_rst   = ($urandom_range(0, 99) == 0);
      r_addr  = 8'($urandom);
      step(r_rst, r_redir, r_addr, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
